// File: rtl/alsu_cmd_sequencer_if.sv
// alsu_cmd_sequencer_if: valid/ready command word channel into the ALSU command sequencer
interface alsu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_data;
    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/alsu_cmd_sequencer.sv
// alsu_cmd_sequencer: FIFO-buffered ALSU command issue with shift/rotate repeat and delayed result strobe
module alsu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int RES_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    alsu_cmd_sequencer_if.slave      cmd,
    input  logic                     flush,
    output logic [2:0]               A,
    output logic [2:0]               B,
    output logic [2:0]               opcode,
    output logic                     cin,
    output logic                     serial_in,
    output logic                     red_op_A,
    output logic                     red_op_B,
    output logic                     bypass_A,
    output logic                     bypass_B,
    output logic                     direction,
    output logic                     issue_valid,
    output logic                     res_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, REPEAT = 2'd2;
    logic [19:0]        mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [1:0]         state;
    logic [3:0]         rep_cnt, rpt_eff;
    logic [15:0]        pins;
    logic [RES_LAT-1:0] res_sh;
    logic [19:0]        head;
    logic               push, pop, hold;
    assign head = mem[rd_ptr];
    // repeat only applies to shift (4) and rotate (5)
    assign rpt_eff = (head[9:7] == 3'd4 || head[9:7] == 3'd5) ? head[19:16] : 4'd0;
    assign cmd.cmd_ready = !rst && fifo_count < CW'(DEPTH);
    assign push = cmd.cmd_valid && cmd.cmd_ready && !flush;
    assign hold = state == REPEAT && rep_cnt != 4'd0;
    assign pop = !hold && fifo_count != '0 && !flush;
    assign {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction} = pins;
    assign res_valid = res_sh[RES_LAT-1];
    assign busy = fifo_count != '0 || state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            state       <= IDLE;
            rep_cnt     <= '0;
            pins        <= '0;
            issue_valid <= 1'b0;
            res_sh      <= '0;
        end else begin
            res_sh <= (res_sh << 1) | RES_LAT'(issue_valid);
            if (push) mem[wr_ptr] <= cmd.cmd_data;
            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
                state       <= IDLE;
                rep_cnt     <= '0;
                pins        <= '0;
                issue_valid <= 1'b0;
            end else begin
                wr_ptr     <= wr_ptr + PW'(push);
                rd_ptr     <= rd_ptr + PW'(pop);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (hold) begin
                    rep_cnt <= rep_cnt - 4'd1;
                end else if (pop) begin
                    pins        <= head[15:0];
                    issue_valid <= 1'b1;
                    rep_cnt     <= rpt_eff;
                    state       <= rpt_eff == 4'd0 ? ISSUE : REPEAT;
                end else begin
                    pins        <= '0;
                    issue_valid <= 1'b0;
                    state       <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// tb_alsu_cmd_sequencer: random and directed stimulus checked every cycle against a queue-based model
module tb_alsu_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int RES_LAT = 2;
    logic clk = 1'b0;
    logic rst, flush;
    logic [2:0] A, B, opcode;
    logic cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic issue_valid, res_valid, busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] dut_pins;
    int vectors = 0, miscompares = 0;
    bit armed = 1'b0;
    logic [19:0] q[$];
    int rem = 0;
    logic [15:0] exp_pins = '0;
    bit rh[$];
    alsu_cmd_sequencer_if bus();
    alsu_cmd_sequencer #(.DEPTH(DEPTH), .RES_LAT(RES_LAT)) dut (
        .clk(clk), .rst(rst), .cmd(bus), .flush(flush),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .direction(direction), .issue_valid(issue_valid),
        .res_valid(res_valid), .busy(busy), .fifo_count(fifo_count)
    );
    assign dut_pins = {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
    always #5 clk = ~clk;
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction
    // Model: remaining issue count of the current command plus a queue of pending words
    task automatic model_step();
        bit rdy;
        logic [19:0] w;
        rdy = !rst && q.size() < DEPTH;
        if (rst) begin
            q.delete();
            rh.delete();
            rem = 0;
            exp_pins = '0;
        end else begin
            rh.push_back(rem > 0);
            if (rh.size() > RES_LAT) void'(rh.pop_front());
            if (flush) begin
                q.delete();
                rem = 0;
                exp_pins = '0;
            end else begin
                if (rem > 1) rem--;
                else if (q.size() > 0) begin
                    w = q.pop_front();
                    exp_pins = w[15:0];
                    rem = (w[9:7] == 3'd4 || w[9:7] == 3'd5) ? int'(w[19:16]) + 1 : 1;
                end else begin
                    rem = 0;
                    exp_pins = '0;
                end
                if (bus.cmd_valid && rdy) q.push_back(bus.cmd_data);
            end
        end
    endtask
    initial forever begin
        @(posedge clk);
        model_step();
    end
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("pins", 32'(dut_pins), 32'(rem > 0 ? exp_pins : 16'h0));
            chk("issue_valid", 32'(issue_valid), 32'(rem > 0));
            chk("res_valid", 32'(res_valid), 32'(rh.size() == RES_LAT && rh[0]));
            chk("busy", 32'(busy), 32'(q.size() != 0 || rem > 0));
            chk("fifo_count", 32'(fifo_count), 32'(q.size()));
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(!rst && q.size() < DEPTH));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [19:0] w);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = w;
        tick();
        bus.cmd_valid = 1'b0;
    endtask
    task automatic drain();
        int k;
        for (k = 0; k < 100 && busy !== 1'b0; k++) tick();
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask
    task automatic count_issues(input int cycles, input logic [2:0] op, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (issue_valid === 1'b1 && opcode === op) n++;
            tick();
        end
    endtask
    initial begin
        int n, k;
        rst = 1'b1;
        flush = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        tick();
        tick();
        armed = 1'b1;
        chk("rst_pins", 32'(dut_pins), 32'd0);
        chk("rst_issue", 32'(issue_valid), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
        tick();
        push(20'h07540);
        chk("single_not_yet", 32'(issue_valid), 32'd0);
        tick();
        chk("single_pins", 32'(dut_pins), 32'h7540);
        chk("single_issue", 32'(issue_valid), 32'd1);
        tick();
        chk("single_one_cycle", 32'(issue_valid), 32'd0);
        chk("single_res_early", 32'(res_valid), 32'd0);
        tick();
        chk("single_res", 32'(res_valid), 32'd1);
        tick();
        chk("single_res_end", 32'(res_valid), 32'd0);
        drain();
        push(20'hF2200);
        for (int i = 0; i < 4; i++) push(20'h00100 | 20'(i << 13));
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = 20'h0A080;
        for (k = 0; k < 40 && bus.cmd_ready !== 1'b1; k++) tick();
        chk("full_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        chk("full_first_pop", 32'(fifo_count), 32'd3);
        tick();
        bus.cmd_valid = 1'b0;
        drain();
        push(20'h02004);
        push(20'h32281);
        count_issues(12, 3'd5, n);
        chk("rotate_issues", 32'(n), 32'd4);
        drain();
        push(20'h70080);
        count_issues(12, 3'd1, n);
        chk("nonshift_issues", 32'(n), 32'd1);
        drain();
        push(20'hA2200);
        push(20'h04100);
        push(20'h08180);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_issue", 32'(issue_valid), 32'd0);
        chk("flush_pins", 32'(dut_pins), 32'd0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_res_inflight", 32'(res_valid), 32'd1);
        tick();
        tick();
        tick();
        push(20'hF2200);
        push(20'h04100);
        push(20'h08180);
        push(20'h0C000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_pins", 32'(dut_pins), 32'd0);
        chk("rst_mid_issue", 32'(issue_valid), 32'd0);
        chk("rst_mid_count", 32'(fifo_count), 32'd0);
        chk("rst_mid_res", 32'(res_valid), 32'd0);
        chk("rst_mid_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_ready_after", 32'(bus.cmd_ready), 32'd1);
        tick();
        for (int i = 0; i < 3000; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_data = 20'($urandom);
            flush = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
